nibble_serial_accum: RTL and testbench

Sequential 8-bit accumulator that sits directly downstream of the 4-bit ripple-carry adder stage. It accepts 4-bit operands over a valid/ready handshake and adds each one into an 8-bit running total in two cycles. Each cycle uses a single 4-bit adder: low nibble first, then high nibble plus the stored carry. It reports a sticky overflow flag and a saturating operand count, and drives the board-level LEDR/HEX display logic.

---
 rtl/nibble_accum_pkg.sv | 18 +
 rtl/nibble_adder.sv | 27 ++
 rtl/nibble_serial_accum.sv | 120 ++++++++++++
 tb/tb_nibble_serial_accum.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_accum_pkg.sv
// Shared types and constants for the nibble-serial accumulator.
// No logic; imported by the adder slice and the accumulator top.
// Optional build macro used by the top: NIBBLE_ACCUM_SAT_EN.
package nibble_accum_pkg;

  localparam int NIB_W = 4;
  localparam int ACC_W = 2 * NIB_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational NIB_W-bit ripple-carry adder slice.
// Latency: none (pure combinational).
// Backpressure: none; the caller owns all sequencing.
module nibble_adder
  import nibble_accum_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic c;

  // Ripple the carry bit by bit from the LSB upward
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < NIB_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_accum.sv
// 8-bit accumulator adding 4-bit operands through one shared 4-bit adder (low then high nibble).
// Latency: accept edge k, result with out_valid=1 in the cycle after edge k+2; one operand per 4 cycles.
// Backpressure: in_ready only in IDLE with clear low; NIBBLE_ACCUM_SAT_EN selects saturating adds.
module nibble_serial_accum
  import nibble_accum_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIB_W-1:0] in_data,
  input  logic             clear,
  output logic [ACC_W-1:0] acc,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic             out_valid
);

  state_t           state_q, state_d;
  logic [NIB_W-1:0] opnd_q, opnd_d;
  logic             carry_q, carry_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             hi_sel;
  logic [NIB_W-1:0] add_a, add_b, add_s;
  logic             add_ci, add_co;

  // Steer the single adder slice: low nibble + operand, or high nibble + stored carry
  always_comb begin
    hi_sel = (state_q == ADD_HI);
    add_a  = hi_sel ? acc_q[ACC_W-1:NIB_W] : acc_q[NIB_W-1:0];
    add_b  = hi_sel ? '0 : opnd_q;
    add_ci = hi_sel & carry_q;
  end

  nibble_adder u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  // Next-state and datapath update for the four-phase add sequence
  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end else if (in_valid) begin
          opnd_d  = in_data;
          state_d = ADD_LO;
        end
      end
      ADD_LO: begin
        acc_d[NIB_W-1:0] = add_s;
        carry_d          = add_co;
        state_d          = ADD_HI;
      end
      ADD_HI: begin
`ifdef NIBBLE_ACCUM_SAT_EN
        if (add_co) acc_d = {ACC_W{1'b1}};
        else        acc_d[ACC_W-1:NIB_W] = add_s;
`else
        acc_d[ACC_W-1:NIB_W] = add_s;
`endif
        if (add_co) ovf_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register all state; reset discards any in-flight operation
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !clear;
  assign acc       = acc_q;
  assign overflow  = ovf_q;
  assign count     = cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_serial_accum.sv
// Scoreboard bench for nibble_serial_accum: stimulus pushes expected results, monitor pops on out_valid.
// Expected results carry the cycle at which out_valid must appear.
// Honours NIBBLE_ACCUM_SAT_EN for the expected wrap/saturate behaviour.
module tb_nibble_serial_accum;
  import nibble_accum_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NIB_W-1:0] in_data = '0;
  logic             clear = 1'b0;
  logic [ACC_W-1:0] acc;
  logic             overflow;
  logic [CNT_W-1:0] count;
  logic             out_valid;

  typedef struct {
    logic [7:0] acc;
    logic       ovf;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference state of the accumulator kept by the bench
  int   m_acc = 0;
  logic m_ovf = 1'b0;
  int   m_cnt = 0;

  nibble_serial_accum dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .acc       (acc),
    .overflow  (overflow),
    .count     (count),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic model_add(input int d, input int k);
    exp_t e;
    m_acc = m_acc + d;
    if (m_acc > 255) begin
      m_ovf = 1'b1;
`ifdef NIBBLE_ACCUM_SAT_EN
      m_acc = 255;
`else
      m_acc = m_acc - 256;
`endif
    end
    if (m_cnt < 15) m_cnt++;
    e.acc = m_acc[7:0];
    e.ovf = m_ovf;
    e.cnt = m_cnt[3:0];
    e.cyc = k + 2;
    q.push_back(e);
  endtask

  // Present one operand from IDLE; returns so the next call accepts at the earliest edge
  task automatic accept(input logic [3:0] d, input logic clr_lo);
    int k;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check("in_ready_idle", int'(in_ready), 1);
    k = cyc + 1;
    model_add(int'(d), k);
    @(negedge clock);
    in_valid = 1'b0;
    clear    = clr_lo;
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    @(posedge clock);
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_acc", int'(acc), int'(e.acc));
        check("sb_ovf", int'(overflow), int'(e.ovf));
        check("sb_cnt", int'(count), int'(e.cnt));
        check("sb_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_acc", int'(acc), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_cnt", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // 9 then 8: low-nibble carry into the high nibble gives 0x11
    accept(4'h9, 1'b0);
    accept(4'h8, 1'b0);
    @(negedge clock);
    check("acc_0x11", int'(acc), 8'h11);

    // clear together with in_valid in IDLE: clear wins, nothing accepted
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    #1;
    check("in_ready_clear", int'(in_ready), 0);
    @(negedge clock);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_acc", int'(acc), 0);
    check("clr_cnt", int'(count), 0);
    check("clr_ovf", int'(overflow), 0);
    m_acc = 0; m_ovf = 1'b0; m_cnt = 0;
    repeat (4) @(negedge clock);

    // in_valid held high for 16 edges: accepts every 4th edge only
    c0 = cyc + 1;
    in_valid = 1'b1;
    in_data  = 4'h1;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) model_add(1, c0 + i);
      #1;
      check("hold_in_ready", int'(in_ready), (i % 4 == 0) ? 1 : 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("hold_acc", int'(acc), 8'h04);
    check("hold_cnt", int'(count), 4);

    // clear during ADD_LO is ignored; a later clear in IDLE works
    accept(4'h3, 1'b1);
    @(negedge clock);
    check("clr_lo_acc", int'(acc), 8'h07);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr2_acc", int'(acc), 0);
    check("clr2_cnt", int'(count), 0);
    m_acc = 0; m_ovf = 1'b0; m_cnt = 0;

    // reset while in ADD_HI discards the operation
    in_valid = 1'b1;
    in_data  = 4'h1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check("mid_acc_lo", int'(acc), 8'h01);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_hi_acc", int'(acc), 0);
    check("rst_hi_out_valid", int'(out_valid), 0);
    check("rst_hi_in_ready", int'(in_ready), 1);
    repeat (3) @(posedge clock);

    // 0xF eighteen times: 0xFF after 17, then wrap (or saturate) with overflow
    for (int n = 1; n <= 18; n++) begin
      accept(4'hF, 1'b0);
      if (n == 17) begin
        @(negedge clock);
        check("f17_acc", int'(acc), 8'hFF);
        check("f17_ovf", int'(overflow), 0);
        check("f17_cnt", int'(count), 15);
      end
    end
    @(negedge clock);
`ifdef NIBBLE_ACCUM_SAT_EN
    check("f18_acc", int'(acc), 8'hFF);
`else
    check("f18_acc", int'(acc), 8'h0E);
`endif
    check("f18_ovf", int'(overflow), 1);
    check("f18_cnt", int'(count), 15);

    repeat (6) @(negedge clock);
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
